// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// uart_rx_pkg : shared constants for the oversampling UART receiver.
// Rev 1.0
// ============================================================================
package uart_rx_pkg;

    localparam int DATA_BITS = 8;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_PARITY    = 3'd3;
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;

    // A zero result flags an unreachable baud rate; callers refuse to elaborate.
    function automatic int calc_divisor(input int clk_freq, input int baud, input int oversample);
        if (baud <= 0 || oversample <= 0) return 0;
        return clk_freq / (baud * oversample);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// uart_baud_tick : free-running sample-tick generator, one tick per DIVISOR clocks.
// Rev 1.0
// ============================================================================
module uart_baud_tick
    import uart_rx_pkg::*;
#(
    parameter int CLK_FREQ   = 25_000_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16
) (
    input  logic Hclock,
    input  logic Hreset,
    output logic tick
);

    localparam int DIVISOR = calc_divisor(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int CW      = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(DIVISOR - 1);

    generate
        if (DIVISOR == 0) begin : g_div_zero
            $error("uart_baud_tick: DIVISOR evaluates to 0");
        end
    endgenerate

    logic [CW-1:0] cnt_q;

    always_ff @(posedge Hclock or negedge Hreset) begin
        if (!Hreset) begin
            cnt_q <= '0;
        end else if (cnt_q == C_LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tick = (cnt_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
// uart_rx_sampler : oversampling UART receiver with majority vote, false-start
// rejection and framing-error strobe. Define UART_RX_PARITY_EN for 8E1 framing.
// Rev 1.0
// ============================================================================
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int CLK_FREQ   = 25_000_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 Hclock,
    input  logic                 Hreset,
    input  logic                 RxD,
    output logic [DATA_BITS-1:0] RxD_data,
    output logic                 RxD_data_ready,
    output logic                 frame_error,
    output logic                 rx_busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_error
`endif
);

    localparam int SCW = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);
    localparam logic [SCW-1:0] C_SC_A    = SCW'(OVERSAMPLE / 2 - 1);
    localparam logic [SCW-1:0] C_SC_B    = SCW'(OVERSAMPLE / 2);
    localparam logic [SCW-1:0] C_SC_DEC  = SCW'(OVERSAMPLE / 2 + 1);
    localparam logic [SCW-1:0] C_SC_LAST = SCW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0]  C_LAST_BIT = BW'(DATA_BITS - 1);

    generate
        if ((OVERSAMPLE % 2) != 0 || OVERSAMPLE < 8) begin : g_os_check
            $error("uart_rx_sampler: OVERSAMPLE must be even and >= 8");
        end
    endgenerate

    logic                 w_tick;
    logic                 sync1_q, rxs_q;
    logic [2:0]           state_q, state_d;
    logic [SCW-1:0]       sc_q, sc_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 s0_q, s0_d, s1_q, s1_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 ready_q, ready_d;
    logic                 ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d;
    logic                 perr_q, perr_d;
`endif
    logic                 w_vote, w_decide;

    uart_baud_tick #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_tick (
        .Hclock(Hclock),
        .Hreset(Hreset),
        .tick  (w_tick)
    );

    assign w_vote   = (s0_q & s1_q) | (s0_q & rxs_q) | (s1_q & rxs_q);
    assign w_decide = w_tick && (sc_q == C_SC_DEC);

    always_ff @(posedge Hclock or negedge Hreset) begin
        if (!Hreset) begin
            sync1_q   <= 1'b1;
            rxs_q     <= 1'b1;
            state_q   <= S_IDLE;
            sc_q      <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            s0_q      <= 1'b1;
            s1_q      <= 1'b1;
            data_q    <= '0;
            ready_q   <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            sync1_q   <= RxD;
            rxs_q     <= sync1_q;
            state_q   <= state_d;
            sc_q      <= sc_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            s0_q      <= s0_d;
            s1_q      <= s1_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
            ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        sc_d      = sc_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        s0_d      = s0_q;
        s1_d      = s1_q;
        data_d    = data_q;
        ready_d   = 1'b0;
        ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        perr_d    = 1'b0;
`endif
        if (w_tick) begin
            sc_d = (sc_q == C_SC_LAST) ? '0 : sc_q + SCW'(1);
            if (sc_q == C_SC_A) s0_d = rxs_q;
            if (sc_q == C_SC_B) s1_d = rxs_q;
            case (state_q)
                S_IDLE: begin
                    if (!rxs_q) begin
                        sc_d    = '0;
                        state_d = S_START;
                    end
                end
                S_START: begin
                    if (w_decide) begin
                        state_d = w_vote ? S_IDLE : S_DATA;
                        bit_d   = '0;
                    end
                end
                S_DATA: begin
                    if (w_decide) begin
                        shift_d = {w_vote, shift_q[DATA_BITS-1:1]};
                        bit_d   = bit_q + BW'(1);
                        if (bit_q == C_LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_decide) begin
                        par_bad_d = w_vote ^ (^shift_q);
                        state_d   = S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (w_decide) begin
                        if (w_vote) begin
`ifdef UART_RX_PARITY_EN
                            if (par_bad_q) begin
                                perr_d = 1'b1;
                            end else begin
                                data_d  = shift_q;
                                ready_d = 1'b1;
                            end
`else
                            data_d  = shift_q;
                            ready_d = 1'b1;
`endif
                            state_d = S_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = S_WAIT_IDLE;
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    if (rxs_q) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        rx_busy        = (state_q != S_IDLE);
        RxD_data       = data_q;
        RxD_data_ready = ready_q;
        frame_error    = ferr_q;
`ifdef UART_RX_PARITY_EN
        parity_error   = perr_q;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_sampler.sv
`default_nettype none
// ============================================================================
// tb_uart_rx_sampler : directed and randomized frames against a byte-level model.
// Rev 1.0
// ============================================================================
module tb_uart_rx_sampler;

    localparam int BT = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       RxD;
    logic [7:0] rx_data;
    logic       rx_ready, ferr, busy;
`ifdef UART_RX_PARITY_EN
    logic       perr;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_cyc = 0;

    logic [7:0] rx_q[$];
    int         lat_q[$];
    int         ferr_cnt;
    bit         busy_seen;
    bit         both_seen;

    uart_rx_sampler #(
        .CLK_FREQ  (1_600_000),
        .BAUD      (100_000),
        .OVERSAMPLE(16)
    ) dut (
        .Hclock        (clk),
        .Hreset        (rst_n),
        .RxD           (RxD),
        .RxD_data      (rx_data),
        .RxD_data_ready(rx_ready),
        .frame_error   (ferr),
        .rx_busy       (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_error  (perr)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_ready) begin
                rx_q.push_back(rx_data);
                lat_q.push_back(cyc - start_cyc);
            end
            if (ferr) ferr_cnt++;
            if (busy) busy_seen = 1'b1;
            if (rx_ready && ferr) both_seen = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        rx_q.delete();
        lat_q.delete();
        ferr_cnt  = 0;
        busy_seen = 1'b0;
        both_seen = 1'b0;
    endtask

    // Positions: 0 = start, 1..8 = data LSB first, 9 = stop. One-cycle glitch at (gpos, goff).
    task automatic send_frame(input logic [7:0] d, input int nbits, input logic stop_v,
                              input int gpos, input int goff);
        logic [9:0] f;
        int npos;
        f    = {stop_v, d, 1'b0};
        npos = (nbits >= 8) ? 10 : nbits + 1;
        for (int p = 0; p < npos; p++) begin
            for (int i = 0; i < BT; i++) begin
                @(negedge clk);
                if (p == 0 && i == 0) start_cyc = cyc;
                RxD = (p == gpos && i == goff) ? ~f[p] : f[p];
            end
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        RxD = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    logic [7:0] exp_q[$];
    logic [7:0] b;
    int         gp;

    initial begin
        rst_n = 1'b0;
        RxD   = 1'b1;
        clear_mon();
        repeat (4) @(negedge clk);
        check("reset_data", {24'd0, rx_data}, 32'h0);
        check("reset_strobes", {29'd0, rx_ready, ferr, busy}, 32'h0);
        rst_n = 1'b1;
        idle(10);
        check("post_reset_busy", {31'd0, busy}, 32'h0);

        // Plain 0xA5
        clear_mon();
        send_frame(8'hA5, 8, 1'b1, -1, 0);
        idle(20);
        check("a5_count", rx_q.size(), 1);
        if (rx_q.size() > 0) begin
            check("a5_data", {24'd0, rx_q[0]}, 32'hA5);
            check("a5_latency", {31'd0, (lat_q[0] >= 150 && lat_q[0] <= 162)}, 32'h1);
        end
        check("a5_ferr", ferr_cnt, 0);

        // 4-cycle glitch while idle
        clear_mon();
        @(negedge clk);
        RxD = 1'b0;
        repeat (4) @(negedge clk);
        RxD = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_strobes", rx_q.size() + ferr_cnt, 0);
        check("glitch_busy_pulse", {31'd0, busy_seen}, 32'h1);
        check("glitch_busy_end", {31'd0, busy}, 32'h0);

        // 0xFF with a one-cycle low spike at bit-3 centre
        clear_mon();
        send_frame(8'hFF, 8, 1'b1, 4, 8);
        idle(20);
        check("spike_count", rx_q.size(), 1);
        if (rx_q.size() > 0) check("spike_data", {24'd0, rx_q[0]}, 32'hFF);

        // Bad stop bit then a good frame
        clear_mon();
        send_frame(8'h3C, 8, 1'b0, -1, 0);
        idle(30);
        check("badstop_ferr", ferr_cnt, 1);
        check("badstop_nostrobe", rx_q.size(), 0);
        check("badstop_hold", {24'd0, rx_data}, 32'hFF);
        send_frame(8'h12, 8, 1'b1, -1, 0);
        idle(20);
        check("after_ferr_count", rx_q.size(), 1);
        if (rx_q.size() > 0) check("after_ferr_data", {24'd0, rx_q[0]}, 32'h12);

        // Break: line low for 40 bit times
        clear_mon();
        @(negedge clk);
        RxD = 1'b0;
        repeat (40 * BT) @(negedge clk);
        check("break_ferr", ferr_cnt, 1);
        check("break_busy", {31'd0, busy}, 32'h1);
        check("break_nostrobe", rx_q.size(), 0);
        idle(20);
        check("break_release", {31'd0, busy}, 32'h0);
        check("break_hold", {24'd0, rx_data}, 32'h12);

        // Reset mid-frame after bit 4 of 0x55
        clear_mon();
        send_frame(8'h55, 5, 1'b1, -1, 0);
        @(negedge clk);
        rst_n = 1'b0;
        RxD   = 1'b1;
        repeat (3) @(negedge clk);
        check("midreset_data", {24'd0, rx_data}, 32'h0);
        check("midreset_busy", {31'd0, busy}, 32'h0);
        rst_n = 1'b1;
        idle(20);
        send_frame(8'h81, 8, 1'b1, -1, 0);
        idle(20);
        check("midreset_count", rx_q.size(), 1);
        if (rx_q.size() > 0) check("midreset_data81", {24'd0, rx_q[0]}, 32'h81);

        // Random back-to-back frames with occasional single-cycle noise
        clear_mon();
        exp_q.delete();
        for (int k = 0; k < 8; k++) begin
            b  = 8'($urandom);
            gp = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 8)) : -1;
            exp_q.push_back(b);
            send_frame(b, 8, 1'b1, gp, int'($urandom_range(0, 15)));
        end
        idle(30);
        check("rand_count", rx_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < rx_q.size()) check($sformatf("rand_data%0d", k), {24'd0, rx_q[k]}, {24'd0, exp_q[k]});
        end
        check("rand_ferr", ferr_cnt, 0);
        check("never_both", {31'd0, both_seen}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
